cmd_respond_burst: RTL and testbench
====================================

Name: cmd_respond_burst

Overview:
Parametrised successor to the single-word command responder. Pops decoded command words from the cmd_dispatcher FIFO and executes write, read or burst-read against an internal register file. Serialises a status header plus data bytes, MSB first, to uart_tx, paced by baud_tick and tx_busy. Sits between cmd_dispatcher and uart_tx in the UART memory-access path.

Parameters:
DATA_W, 32, register width in bits; multiple of 8, range 8..64
ADDR_W, 8, register address width
REG_DEPTH, 256, number of registers; must be <= 2**ADDR_W
MAX_BURST, 16, maximum burst-read length in words; power of 2, <= 2**DATA_W
(derived localparams) CMD_W = 2+ADDR_W+DATA_W; NBYTES = DATA_W/8; LEN_W = $clog2(MAX_BURST)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cmd_fifo_rd_data  in  CMD_W  command word: [CMD_W-1:CMD_W-2] opcode, next ADDR_W bits addr, low DATA_W bits payload
cmd_fifo_valid  in  1  FIFO non-empty
cmd_fifo_rd_en  out  1  single-cycle pop; rd_data is valid the following cycle
baud_tick  in  1  one-cycle pacing strobe
tx_busy  in  1  uart_tx is shifting a byte
tx_data  out  8  response byte
tx_data_en  out  1  single-cycle byte strobe to uart_tx
busy  out  1  high whenever FSM is not IDLE
err_count  out  16  saturating count of error responses

Behaviour:
- Reset (rst=0, async): FSM to IDLE. cmd_fifo_rd_en=0, tx_data=8'h00, tx_data_en=0, busy=0, err_count=0. Register file contents are NOT reset. A command in flight is discarded; no partial response resumes.
- Opcodes: 00 NOP (popped, no response); 01 WRITE regs[addr]=payload; 10 READ; 11 BURST_READ with len = payload[LEN_W-1:0]+1 words from addr upward.
- Headers: 8'hAC write ack; 8'hAD read data; 8'hE1 address error; 8'hE2 reserved (unused, opcode space is full).
- FSM: IDLE -> POP (assert cmd_fifo_rd_en 1 cycle when cmd_fifo_valid) -> DECODE (latch word, range check) -> WRITE | RD_REQ | SEND_HDR | IDLE(NOP).
  - WRITE: 1-cycle write, then SEND_HDR with 8'hAC.
  - RD_REQ: regfile read has 1-cycle latency; data is latched into a shift register, then SEND_HDR 8'hAD (first word only), then SEND_DATA for NBYTES bytes.
  - After the last byte of a word: NEXT increments addr and decrements the remaining count; if count > 0 -> RD_REQ, else -> IDLE.
- Range check in DECODE: WRITE/READ require addr < REG_DEPTH. BURST requires addr+len <= REG_DEPTH, computed at ADDR_W+1 bits with no wrap-around. On failure send single header 8'hE1 with no data, increment err_count (saturates at 16'hFFFF), and leave registers unmodified.
- Byte issue rule: tx_data_en pulses only on a cycle with baud_tick=1 and tx_busy=0. tx_data is held stable from that cycle until the next issue. Exactly one byte per pulse.
  - uart_tx asserts tx_busy within 1 clk of tx_data_en. The FSM must additionally ignore the next baud_tick if it falls in that cycle, so it never double-issues.
- Back-to-back commands: IDLE may pop in the cycle after the last byte issue. Maximum of one command in flight.
- cmd_fifo_valid dropping while not in IDLE: ignored.
- Burst throughput is bounded by the baud rate; the regfile read is hidden behind byte serialisation.

Decomposition:
- Package cmd_respond_pkg: opcode enum (OP_NOP, OP_WRITE, OP_READ, OP_BURST), header constants (HDR_WACK, HDR_RDATA, HDR_EADDR), FSM state enum, and a packed struct for the command-word fields parametrised via ADDR_W/DATA_W localparams.
- One sub-module: cmd_respond_regfile (REG_DEPTH x DATA_W, synchronous write, registered 1-cycle read). Its array is named regs so benches can backdoor-load it.

Test Plan:
- WRITE addr 8'h10 data 32'hDEADBEEF, then READ 8'h10 -> tx bytes AC, then AD DE AD BE EF; err_count=0.
- Backdoor regs[4..7]=1,2,3,4, then BURST addr 4 len-field 3 -> AD, 00 00 00 01, 00 00 00 02, 00 00 00 03, 00 00 00 04 (17 bytes); busy low afterwards.
- REG_DEPTH=200: READ addr 200 -> E1 only; BURST addr 198 len-field 3 -> E1 with no data; err_count=2; regs unchanged.
- NOP followed by READ addr 0 -> no bytes for the NOP; READ response follows with exactly 2 pops seen.
- Hold tx_busy=1 for 5 baud_ticks mid-read -> no tx_data_en during the hold; bytes resume in order with none dropped or duplicated.
- Assert rst mid-burst after 6 bytes -> outputs return to reset values within the same cycle; after release the FIFO holds the next READ, which responds normally.

Source files
------------

// File: rtl/cmd_respond_pkg.sv
// Shared types and constants for the burst-capable command responder:
// opcodes, response headers, FSM states and the command-word layout.
package cmd_respond_pkg;

    localparam int PKG_ADDR_W = 8;
    localparam int PKG_DATA_W = 32;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_BURST = 2'b11
    } opcode_e;

    localparam logic [7:0] HDR_WACK  = 8'hAC;
    localparam logic [7:0] HDR_RDATA = 8'hAD;
    localparam logic [7:0] HDR_EADDR = 8'hE1;
    // The opcode space is full, so this header is never emitted.
    localparam logic [7:0] HDR_ERSVD = 8'hE2;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_POP       = 4'd1,
        ST_DECODE    = 4'd2,
        ST_WRITE     = 4'd3,
        ST_RD_REQ    = 4'd4,
        ST_RD_LATCH  = 4'd5,
        ST_SEND_HDR  = 4'd6,
        ST_SEND_DATA = 4'd7,
        ST_NEXT      = 4'd8
    } state_e;

    typedef struct packed {
        opcode_e                 op;
        logic [PKG_ADDR_W-1:0]   addr;
        logic [PKG_DATA_W-1:0]   payload;
    } cmd_word_t;

endpackage

// File: rtl/cmd_respond_regfile.sv
// Register file for the command responder: synchronous write, registered
// single-cycle read. Contents are deliberately not reset.
module cmd_respond_regfile #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int REG_DEPTH = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] regs [REG_DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            regs[addr] <= wdata;
        end
        if (rd_en) begin
            rd_data_reg <= regs[addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/cmd_respond_burst.sv
// Command responder: pops command words, executes write/read/burst-read on
// the register file and serialises header + data bytes, MSB first, to uart_tx.
module cmd_respond_burst
    import cmd_respond_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int REG_DEPTH = 256,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2+ADDR_W+DATA_W-1:0] cmd_fifo_rd_data,
    input  logic                       cmd_fifo_valid,
    output logic                       cmd_fifo_rd_en,
    input  logic                       baud_tick,
    input  logic                       tx_busy,
    output logic [7:0]                 tx_data,
    output logic                       tx_data_en,
    output logic                       busy,
    output logic [15:0]                err_count
);

    localparam int CMD_W  = 2 + ADDR_W + DATA_W;
    localparam int NBYTES = DATA_W / 8;
    localparam int LEN_W  = $clog2(MAX_BURST);
    localparam int CNT_W  = LEN_W + 1;
    localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(REG_DEPTH);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NBYTES - 1);

    state_e            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg, shift_reg, rd_data;
    logic [CNT_W-1:0]  count_reg;
    logic [BC_W-1:0]   byte_cnt_reg;
    logic [7:0]        hdr_reg, tx_data_reg, byte_out;
    logic              first_reg, issued_reg, issue;
    logic [15:0]       err_count_reg;

    opcode_e           cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_payload;
    logic [CNT_W-1:0]  burst_len;
    logic [ADDR_W:0]   burst_end;
    logic              range_err;

    assign cmd_op      = opcode_e'(cmd_fifo_rd_data[CMD_W-1 -: 2]);
    assign cmd_addr    = cmd_fifo_rd_data[DATA_W +: ADDR_W];
    assign cmd_payload = cmd_fifo_rd_data[DATA_W-1:0];
    assign burst_len   = CNT_W'(cmd_payload[LEN_W-1:0]) + CNT_W'(1);
    // One extra bit so a burst running past the top of the address space cannot wrap.
    assign burst_end   = {1'b0, cmd_addr} + (ADDR_W+1)'(burst_len);

    always_comb begin
        range_err = 1'b0;
        case (cmd_op)
            OP_WRITE, OP_READ: range_err = ({1'b0, cmd_addr} >= DEPTH_LIM);
            OP_BURST:          range_err = (burst_end > DEPTH_LIM);
            default:           range_err = 1'b0;
        endcase
    end

    // uart_tx may raise tx_busy one cycle late, so the cycle after an issue is blocked.
    assign issue    = ((state_reg == ST_SEND_HDR) || (state_reg == ST_SEND_DATA))
                      && baud_tick && !tx_busy && !issued_reg;
    assign byte_out = (state_reg == ST_SEND_HDR) ? hdr_reg : shift_reg[DATA_W-1 -: 8];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (cmd_fifo_valid) state_next = ST_POP;
            ST_POP:       state_next = ST_DECODE;
            ST_DECODE: begin
                if (cmd_op == OP_NOP)        state_next = ST_IDLE;
                else if (range_err)          state_next = ST_SEND_HDR;
                else if (cmd_op == OP_WRITE) state_next = ST_WRITE;
                else                         state_next = ST_RD_REQ;
            end
            ST_WRITE:     state_next = ST_SEND_HDR;
            ST_RD_REQ:    state_next = ST_RD_LATCH;
            ST_RD_LATCH:  state_next = first_reg ? ST_SEND_HDR : ST_SEND_DATA;
            ST_SEND_HDR:  if (issue) state_next = (hdr_reg == HDR_RDATA) ? ST_SEND_DATA : ST_IDLE;
            ST_SEND_DATA: if (issue && (byte_cnt_reg == LAST_BYTE)) state_next = ST_NEXT;
            ST_NEXT:      state_next = (count_reg > CNT_W'(1)) ? ST_RD_REQ : ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            shift_reg     <= '0;
            count_reg     <= '0;
            byte_cnt_reg  <= '0;
            hdr_reg       <= '0;
            tx_data_reg   <= '0;
            first_reg     <= 1'b0;
            issued_reg    <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg  <= state_next;
            issued_reg <= issue;
            if (issue) begin
                tx_data_reg <= byte_out;
            end
            case (state_reg)
                ST_DECODE: begin
                    addr_reg  <= cmd_addr;
                    wdata_reg <= cmd_payload;
                    first_reg <= 1'b1;
                    count_reg <= (cmd_op == OP_BURST) ? burst_len : CNT_W'(1);
                    if (range_err) begin
                        hdr_reg <= HDR_EADDR;
                        if (err_count_reg != 16'hFFFF) begin
                            err_count_reg <= err_count_reg + 16'd1;
                        end
                    end else if (cmd_op == OP_WRITE) begin
                        hdr_reg <= HDR_WACK;
                    end else begin
                        hdr_reg <= HDR_RDATA;
                    end
                end
                ST_RD_LATCH: begin
                    shift_reg    <= rd_data;
                    byte_cnt_reg <= '0;
                end
                ST_SEND_HDR: if (issue) first_reg <= 1'b0;
                ST_SEND_DATA: begin
                    if (issue) begin
                        shift_reg    <= shift_reg << 8;
                        byte_cnt_reg <= byte_cnt_reg + BC_W'(1);
                    end
                end
                ST_NEXT: begin
                    addr_reg  <= addr_reg + ADDR_W'(1);
                    count_reg <= count_reg - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    cmd_respond_regfile #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .REG_DEPTH (REG_DEPTH)
    ) u_regfile (
        .clk     (clk),
        .we      (state_reg == ST_WRITE),
        .rd_en   (state_reg == ST_RD_REQ),
        .addr    (addr_reg),
        .wdata   (wdata_reg),
        .rd_data (rd_data)
    );

    assign cmd_fifo_rd_en = (state_reg == ST_POP);
    assign busy           = (state_reg != ST_IDLE);
    assign tx_data_en     = issue;
    assign tx_data        = issue ? byte_out : tx_data_reg;
    assign err_count      = err_count_reg;

endmodule

// File: tb/tb_cmd_respond_burst.sv
// Bench for cmd_respond_burst: FIFO and uart_tx models around the DUT, a byte
// scoreboard fed at command push time, a vector table and corner-case sequences.
module tb_cmd_respond_burst;
    import cmd_respond_pkg::*;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 8;
    localparam int REG_DEPTH = 200;
    localparam int MAX_BURST = 16;
    localparam int CMD_W     = 2 + ADDR_W + DATA_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [CMD_W-1:0] cmd_fifo_rd_data = '0;
    logic             cmd_fifo_valid = 1'b0;
    logic             cmd_fifo_rd_en;
    logic             baud_tick = 1'b0;
    logic             tx_busy = 1'b0;
    logic [7:0]       tx_data;
    logic             tx_data_en;
    logic             busy;
    logic [15:0]      err_count;

    always #5 clk = ~clk;

    cmd_respond_burst #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .REG_DEPTH (REG_DEPTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_fifo_rd_data (cmd_fifo_rd_data),
        .cmd_fifo_valid   (cmd_fifo_valid),
        .cmd_fifo_rd_en   (cmd_fifo_rd_en),
        .baud_tick        (baud_tick),
        .tx_busy          (tx_busy),
        .tx_data          (tx_data),
        .tx_data_en       (tx_data_en),
        .busy             (busy),
        .err_count        (err_count)
    );

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [31:0] payload;
        logic [7:0]  exp_hdr;
        int          exp_err;
    } vec_t;

    vec_t             vecs [12];
    int               vectors = 0;
    int               miscompares = 0;
    logic [7:0]       exp_q [$];
    logic [CMD_W-1:0] fifo_q [$];
    logic [31:0]      model_regs [256];
    logic [7:0]       exp_b;
    logic [6:0]       tick_pat = 7'b1101101;
    int               rx_count = 0, pops = 0, cyc = 0, busy_left = 0;
    bit               saw_en = 0, late = 0, pop_pending = 0, hold_busy = 0;
    logic             prev_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Queue a command for the FIFO model and the bytes it must produce.
    task automatic push_cmd(input logic [1:0] op, input logic [7:0] addr,
                            input logic [31:0] payload, input logic [7:0] hdr);
        int len;
        logic [31:0] w;
        fifo_q.push_back({op, addr, payload});
        if (op == 2'b00) return;
        exp_q.push_back(hdr);
        len = (op == 2'b11) ? int'(payload[3:0]) + 1 : 1;
        if (hdr == 8'hAD) begin
            for (int k = 0; k < len; k++) begin
                w = model_regs[int'(addr) + k];
                for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
            end
        end
        if (op == 2'b01 && hdr == 8'hAC) model_regs[addr] = payload;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !busy && !pop_pending) done = 1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: %0d bytes outstanding, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Output monitor: byte scoreboard and issue-rule checks.
    always @(negedge clk) begin
        if (tx_data_en) begin
            rx_count++;
            saw_en = 1;
            vectors++;
            if (!baud_tick || tx_busy || prev_en) begin
                miscompares++;
                $display("FAIL issue_rule: tick=%0b busy=%0b prev_en=%0b, required 1/0/0",
                         baud_tick, tx_busy, prev_en);
            end
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_byte: got %02h, required no byte", tx_data);
            end else begin
                exp_b = exp_q.pop_front();
                check("tx_byte", 32'(tx_data), 32'(exp_b));
            end
        end
        prev_en = tx_data_en;
        if (cmd_fifo_rd_en) begin
            pops++;
            pop_pending = 1;
        end
    end

    // Input models: irregular baud ticks, uart_tx busy raised one cycle late, FIFO.
    always @(posedge clk) begin
        #1;
        cyc++;
        baud_tick = tick_pat[cyc % 7];
        if (busy_left > 0) busy_left--;
        if (late) begin
            late = 0;
            busy_left = 5;
        end
        if (saw_en) begin
            saw_en = 0;
            late = 1;
        end
        tx_busy = hold_busy || (busy_left > 0);
        if (pop_pending) begin
            pop_pending = 0;
            if (fifo_q.size() > 0) cmd_fifo_rd_data = fifo_q.pop_front();
        end
        cmd_fifo_valid = (fifo_q.size() > 0);
    end

    initial begin
        int p0, r0, ticks;

        vecs[0]  = '{2'b01, 8'h10, 32'hDEADBEEF, 8'hAC, 0};
        vecs[1]  = '{2'b10, 8'h10, 32'h0,        8'hAD, 0};
        vecs[2]  = '{2'b01, 8'h00, 32'h12345678, 8'hAC, 0};
        vecs[3]  = '{2'b01, 8'hC6, 32'hA5A50001, 8'hAC, 0};
        vecs[4]  = '{2'b01, 8'hC7, 32'hCAFEF00D, 8'hAC, 0};
        vecs[5]  = '{2'b10, 8'h00, 32'h0,        8'hAD, 0};
        vecs[6]  = '{2'b11, 8'hC6, 32'h1,        8'hAD, 0};
        vecs[7]  = '{2'b10, 8'hC8, 32'h0,        8'hE1, 1};
        vecs[8]  = '{2'b11, 8'hC6, 32'h3,        8'hE1, 2};
        vecs[9]  = '{2'b01, 8'hC8, 32'h11111111, 8'hE1, 3};
        vecs[10] = '{2'b11, 8'hFE, 32'h3,        8'hE1, 4};
        vecs[11] = '{2'b10, 8'hC7, 32'h0,        8'hAD, 4};

        repeat (3) @(negedge clk);
        check("reset_rd_en", 32'(cmd_fifo_rd_en), 0);
        check("reset_tx_data", 32'(tx_data), 0);
        check("reset_tx_data_en", 32'(tx_data_en), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_err_count", 32'(err_count), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            push_cmd(vecs[i].op, vecs[i].addr, vecs[i].payload, vecs[i].exp_hdr);
            wait_idle($sformatf("vec%0d", i));
            check($sformatf("err_count_vec%0d", i), 32'(err_count), 32'(vecs[i].exp_err));
            $display("vec %0d op=%0d addr=%02h hdr=%02h err_count=%0d",
                     i, vecs[i].op, vecs[i].addr, vecs[i].exp_hdr, err_count);
        end

        // NOP must be popped silently ahead of the READ.
        p0 = pops;
        push_cmd(2'b00, 8'h00, 32'h0, 8'h00);
        push_cmd(2'b10, 8'h00, 32'h0, 8'hAD);
        wait_idle("nop_read");
        check("nop_read_pops", 32'(pops - p0), 2);
        $display("nop+read pops=%0d", pops - p0);

        // Backdoor-loaded burst of four words.
        for (int k = 0; k < 4; k++) begin
            dut.u_regfile.regs[4 + k] = 32'(k + 1);
            model_regs[4 + k] = 32'(k + 1);
        end
        r0 = rx_count;
        push_cmd(2'b11, 8'h04, 32'h3, 8'hAD);
        wait_idle("burst4");
        check("burst4_bytes", 32'(rx_count - r0), 17);
        $display("burst addr=04 len=4 bytes=%0d", rx_count - r0);

        // tx_busy held across 5 baud ticks in the middle of a read.
        r0 = rx_count;
        push_cmd(2'b10, 8'h10, 32'h0, 8'hAD);
        for (int i = 0; i < 2000 && rx_count < r0 + 2; i++) @(negedge clk);
        hold_busy = 1;
        @(negedge clk);
        #2;
        p0 = rx_count;
        ticks = 0;
        for (int i = 0; i < 200 && ticks < 5; i++) begin
            @(negedge clk);
            if (baud_tick) ticks++;
        end
        #2;
        check("hold_no_issue", 32'(rx_count - p0), 0);
        hold_busy = 0;
        wait_idle("hold_read");
        check("hold_read_bytes", 32'(rx_count - r0), 5);
        $display("held read bytes=%0d", rx_count - r0);

        // Reset mid-burst after six bytes; the next READ must then respond normally.
        r0 = rx_count;
        push_cmd(2'b11, 8'h04, 32'h3, 8'hAD);
        for (int i = 0; i < 4000 && rx_count < r0 + 6; i++) @(negedge clk);
        check("pre_reset_bytes", 32'(rx_count - r0), 6);
        rst = 1'b0;
        #1;
        check("midrst_tx_data_en", 32'(tx_data_en), 0);
        check("midrst_tx_data", 32'(tx_data), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_rd_en", 32'(cmd_fifo_rd_en), 0);
        check("midrst_err_count", 32'(err_count), 0);
        exp_q.delete();
        push_cmd(2'b10, 8'h10, 32'h0, 8'hAD);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        r0 = rx_count;
        wait_idle("post_reset_read");
        check("post_reset_bytes", 32'(rx_count - r0), 5);
        check("post_reset_err_count", 32'(err_count), 0);
        $display("post-reset read bytes=%0d", rx_count - r0);

        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
